// File: rtl/forest_vote_accum.sv
// Purpose : accumulates 1-bit tree votes per class, then picks the class with most votes.
// Latency : last transfer in cycle T -> out_valid in cycle T+NUM_CLASSES+1.
// Backpr. : in_ready drops while scanning/holding; the winner is held until out_ready.
// Ports   : clk/rst (async active-high); in_valid/in_ready/in_class/in_vote/in_last;
//           out_valid/out_ready/out_class/out_votes/out_sat.
module forest_vote_accum #(
    parameter int NUM_CLASSES = 6,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_class,
    input  logic             in_vote,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_class,
    output logic [CNT_W-1:0] out_votes,
    output logic             out_sat
);

    typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       LAST_IDX = 4'(NUM_CLASSES - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_run;       // in_ready waits for the first edge after reset
    logic [CNT_W-1:0] r_cnt [NUM_CLASSES];
    logic             r_sat;
    logic [3:0]       r_idx;
    logic [3:0]       r_best_idx;
    logic [CNT_W-1:0] r_best_cnt;

    logic             w_xfer;
    logic             w_release;
    logic             w_scan_last;
    logic [CNT_W-1:0] w_scan_cnt;
    logic             w_better;
    logic [3:0]       w_new_idx;
    logic [CNT_W-1:0] w_new_cnt;

    assign w_xfer      = in_valid && in_ready;
    assign w_release   = (r_state == HOLD) && out_ready;
    assign w_scan_last = (r_state == SCAN) && (r_idx == LAST_IDX);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_xfer && in_last) w_next = SCAN;
            SCAN:    if (r_idx == LAST_IDX) w_next = HOLD;
            HOLD:    if (out_ready)         w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == ACCUM) && r_run;
        out_valid = (r_state == HOLD);
    end

    // ---------------- vote counters ----------------
    // Out-of-range classes match no counter, so their vote is dropped while
    // in_last still moves the FSM on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
            r_sat <= 1'b0;
        end else if (w_release) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
            r_sat <= 1'b0;
        end else if (w_xfer && in_vote) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (in_class == 4'(c)) begin
                    if (r_cnt[c] == CNT_MAX) r_sat    <= 1'b1;
                    else                     r_cnt[c] <= r_cnt[c] + 1'b1;
                end
            end
        end
    end

    // ---------------- scan compare ----------------
    always_comb begin
        w_scan_cnt = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (r_idx == 4'(c)) w_scan_cnt = r_cnt[c];
        end
    end

    // Strictly greater only: ties keep the earlier (lower) index.
    assign w_better  = (w_scan_cnt > r_best_cnt);
    assign w_new_idx = w_better ? r_idx      : r_best_idx;
    assign w_new_cnt = w_better ? w_scan_cnt : r_best_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end else if (r_state == SCAN) begin
            r_idx      <= w_scan_last ? 4'd0 : r_idx + 4'd1;
            r_best_idx <= w_new_idx;
            r_best_cnt <= w_new_cnt;
        end else begin
            // Outside SCAN the best is parked at class 0 / 0 votes for the next scan.
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
        end
    end

    // ---------------- result registers ----------------
    // Loaded with the final compare on the edge that enters HOLD; stable otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_class <= '0;
            out_votes <= '0;
            out_sat   <= 1'b0;
        end else if (w_scan_last) begin
            out_class <= w_new_idx;
            out_votes <= w_new_cnt;
            out_sat   <= r_sat;
        end
    end

endmodule

// File: tb/tb_forest_vote_accum.sv
module tb_forest_vote_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_class = '0;
    logic       in_vote = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_class;
    logic [5:0] out_votes;
    logic       out_sat;

    int n_pass = 0;
    int n_tot  = 0;

    forest_vote_accum #(.NUM_CLASSES(6), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_vote   (in_vote),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_votes (out_votes),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One transfer; called #1 after an edge while in ACCUM.
    task automatic send(input logic [3:0] cls, input logic vote, input logic last);
        in_valid = 1'b1;
        in_class = cls;
        in_vote  = vote;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vote  = 1'b0;
        in_last  = 1'b0;
    endtask

    // Counts edges after the last transfer edge until out_valid rises (bounded).
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  e;
        bit  ok;

        // ---- reset state ----
        #1;
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_class", 32'(out_class), 0);
        chk("rst_out_votes", 32'(out_votes), 0);
        chk("rst_out_sat",   32'(out_sat), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready_clocked", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_before_edge", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", 32'(in_ready), 1);

        // ---- counting and latency: 2,2,4,2(last) ----
        send(2, 1, 0);
        send(2, 1, 0);
        send(4, 1, 0);
        send(2, 1, 1);
        chk("scan_in_ready", 32'(in_ready), 0);
        wait_valid(e);
        chk("lat_edges", 32'(e), 6);        // cycle T+7
        chk("cnt_class", 32'(out_class), 2);
        chk("cnt_votes", 32'(out_votes), 3);
        chk("cnt_sat",   32'(out_sat), 0);
        chk("hold_in_ready", 32'(in_ready), 0);
        release_out();
        chk("rel_out_valid", 32'(out_valid), 0);
        chk("rel_in_ready",  32'(in_ready), 1);

        // ---- tie: 1,3,3,1 plus a zero vote that must not count ----
        send(1, 1, 0);
        send(3, 1, 0);
        send(3, 0, 0);
        send(3, 1, 0);
        send(1, 1, 1);
        wait_valid(e);
        chk("tie_class", 32'(out_class), 1);
        chk("tie_votes", 32'(out_votes), 2);
        release_out();

        // ---- saturation: 70 votes to class 5 ----
        for (int i = 0; i < 69; i++) send(5, 1, 0);
        send(5, 1, 1);
        wait_valid(e);
        chk("sat_class", 32'(out_class), 5);
        chk("sat_votes", 32'(out_votes), 63);
        chk("sat_flag",  32'(out_sat), 1);
        release_out();
        send(0, 1, 1);
        wait_valid(e);
        chk("post_sat_class", 32'(out_class), 0);
        chk("post_sat_votes", 32'(out_votes), 1);
        chk("post_sat_flag",  32'(out_sat), 0);
        release_out();

        // ---- backpressure: 10 cycles of out_ready=0 with a vote offered ----
        send(4, 1, 0);
        send(4, 1, 1);
        wait_valid(e);
        in_valid = 1'b1;
        in_class = 4'd4;
        in_vote  = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_class !== 4'd4 ||
                out_votes !== 6'd2 || out_sat !== 1'b0) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 1);
        release_out();
        in_valid = 1'b0;
        in_vote  = 1'b0;
        send(1, 1, 1);
        wait_valid(e);
        chk("bp_next_class", 32'(out_class), 1);
        chk("bp_next_votes", 32'(out_votes), 1);
        release_out();

        // ---- reset on the 3rd SCAN cycle ----
        send(3, 1, 0);
        send(3, 1, 1);                       // now in SCAN cycle 1
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;                                  // SCAN cycle 3
        rst = 1'b1;
        #2;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready",  32'(in_ready), 0);
        chk("mid_rst_out_class", 32'(out_class), 0);
        chk("mid_rst_out_votes", 32'(out_votes), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("mid_rst_no_valid", 32'(ok), 1);
        send(5, 1, 1);
        wait_valid(e);
        chk("mid_rst_next_class", 32'(out_class), 5);
        chk("mid_rst_next_votes", 32'(out_votes), 1);
        release_out();

        // ---- illegal class as the only transfer ----
        send(9, 1, 1);
        wait_valid(e);
        chk("illegal_lat",   32'(e), 6);
        chk("illegal_class", 32'(out_class), 0);
        chk("illegal_votes", 32'(out_votes), 0);
        release_out();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/forest_vote_accum.md
FOREST_VOTE_ACCUM -- requirements
Module: forest_vote_accum

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 6: number of classes in the ensemble; legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 6: width of each per-class vote counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a tree result is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a tree result this cycle.
REQ-007 SHALL have port in_class, input, 4 bits: class index that the evaluated classN_treeM belongs to.
REQ-008 SHALL have port in_vote, input, 1 bit: the 1-bit tree output.
REQ-009 SHALL have port in_last, input, 1 bit: this is the final tree result for the current sample.
REQ-010 SHALL have port out_valid, output, 1 bit: a winner is presented.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the winner.
REQ-012 SHALL have port out_class, output, 4 bits: index of the winning class.
REQ-013 SHALL have port out_votes, output, CNT_W bits: vote count of the winning class.
REQ-014 SHALL have port out_sat, output, 1 bit: at least one counter saturated during this sample.

Function
REQ-015 SHALL implement the states ACCUM, SCAN and HOLD, with ACCUM entered on reset.
REQ-016 SHALL drive in_ready=1 only in ACCUM, and SHALL drive in_ready=0 in SCAN and HOLD.
REQ-017 SHALL define an input transfer as a cycle with in_valid=1 and in_ready=1; no other cycle changes the counters.
REQ-018 SHALL, on a transfer with in_vote=1 and in_class<NUM_CLASSES, increment cnt[in_class] by 1, saturating at 2^CNT_W-1.
REQ-019 SHALL set an internal sticky sat flag when an increment is attempted on a counter already at 2^CNT_W-1.
REQ-020 SHALL discard the vote of a transfer with in_class>=NUM_CLASSES, while still honouring that transfer's in_last.
REQ-021 SHALL count a vote carried on the in_last transfer before the scan starts, and on that transfer SHALL move ACCUM->SCAN on the next edge.
REQ-022 SHALL, in SCAN, examine one class per cycle in index order 0..NUM_CLASSES-1, keeping best index and best count.
REQ-023 SHALL replace the best only on a strictly greater count, so ties resolve to the lowest class index and all-zero counts give class 0 with 0 votes.
REQ-024 SHALL, after examining index NUM_CLASSES-1, move SCAN->HOLD.
REQ-025 SHALL give a latency of exactly NUM_CLASSES+1 cycles: last transfer at edge T puts out_valid=1 in cycle T+NUM_CLASSES+1 (cycle 7 after the transfer for the default).
REQ-026 SHALL, in HOLD, hold out_valid=1 and keep out_class, out_votes and out_sat stable until out_ready=1.
REQ-027 SHALL, on a HOLD cycle with out_ready=1, clear all counters and sat, return to ACCUM and drive out_valid=0 from the next cycle.
REQ-028 SHALL keep in_ready=0 in the HOLD cycle that completes the handshake, so the next sample's first transfer occurs no earlier than the following cycle.
REQ-029 SHALL treat out_ready as don't-care outside HOLD.
REQ-030 SHALL register out_class, out_votes and out_sat so they update only on entry to HOLD, and SHALL drive out_sat as a copy of sat.

Reset
REQ-031 SHALL, while rst=1 and independent of clk, force state=ACCUM, all counters=0, sat=0, best=0, out_valid=0, out_class=0, out_votes=0, out_sat=0 and in_ready=0.
REQ-032 SHALL, after rst deasserts, drive in_ready=1 from the first rising edge onward.
REQ-033 SHALL, on reset asserted mid-ACCUM, mid-SCAN or in HOLD, abandon the sample with no partial result ever presented.

Verification
REQ-034 SHALL cover vote counting and latency: votes for classes (2,2,4,2 with last) -> out_valid 7 cycles after last, out_class=2, out_votes=3, out_sat=0.
REQ-035 SHALL cover the tie rule: votes for classes 1,3,3,1 -> out_class=1, out_votes=2.
REQ-036 SHALL cover saturation: 70 votes to class 5 with CNT_W=6 -> out_votes=63, out_sat=1; the next sample, with 1 vote for class 0, -> out_class=0, out_votes=1, out_sat=0.
REQ-037 SHALL cover backpressure: out_ready held 0 for 10 cycles -> outputs stable and in_ready=0 throughout; a vote offered meanwhile is not counted.
REQ-038 SHALL cover an illegal class: in_class=9 with in_vote=1 and in_last=1 as the only transfer -> out_class=0, out_votes=0.
REQ-039 SHALL cover reset during SCAN: rst pulsed on the 3rd SCAN cycle -> out_valid never rises; the next sample's result is computed from zeroed counters.
